// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch
//   Instruction fetch unit for the single-cycle MIPS core. Owns the program
//   counter, fetches one word at a time from instruction memory over a
//   req/rdy handshake, presents the registered instruction to the decoder
//   and, once the decoder retires it, forms the next PC from NPCOp.
//   Wait-state memories are supported; a memory that never answers, or a
//   register jump to a misaligned target, parks the unit in a sticky fault
//   state that only reset leaves.
//
// Parameters
//   RESET_PC       PC loaded by reset
//   FETCH_TIMEOUT  wait cycles tolerated for imem_rdy before faulting (1..255)
//
// Ports
//   clk          in   rising-edge clock
//   rstn         in   asynchronous active-low reset
//   hold         in   boot hold, keeps the unit idle while high (IDLE only)
//   imem_req     out  fetch request, held until imem_rdy
//   imem_addr    out  fetch address (always the current pc)
//   imem_rdy     in   imem_rdata valid this cycle (looked at only in FETCH)
//   imem_rdata   in   instruction word from memory
//   Instru       out  registered instruction for the decoder
//   instr_valid  out  Instru valid and waiting for execution
//   pc           out  address of Instru
//   pc_plus4     out  pc + 4, link value for jal/jalr
//   NPCOp        in   next-pc select: 00 pc+4, 01 branch, 10 j/jal, 11 jr/jalr
//   rs_val       in   register jump target used for NPCOp = 11
//   exec_done    in   current instruction retired, NPCOp/rs_val valid
//   fault        out  sticky fault flag
//   fault_code   out  00 none, 01 misaligned target, 10 fetch timeout
// ---------------------------------------------------------------------------
module ifu_fetch #(
   parameter logic [31:0] RESET_PC      = 32'h0000_3000,
   parameter int unsigned FETCH_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        hold,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rdy,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instru,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic [1:0]  NPCOp,
   input  logic [31:0] rs_val,
   input  logic        exec_done,
   output logic        fault,
   output logic [1:0]  fault_code
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   localparam logic [1:0] NPC_SEQ    = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_REG    = 2'b11;

   localparam logic [1:0] CODE_NONE      = 2'b00;
   localparam logic [1:0] CODE_MISALIGN  = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT   = 2'b10;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(FETCH_TIMEOUT);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [1:0]  code_q, code_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;

   logic [31:0] seq_pc;
   logic [31:0] branch_off;
   logic [31:0] branch_pc;
   logic [31:0] jump_pc;
   logic [31:0] next_pc;
   logic        target_misaligned;

   // ------------------------------------------------------------------
   // Next-PC formation. All arithmetic wraps silently modulo 2^32.
   // ------------------------------------------------------------------
   assign seq_pc     = pc_q + 32'd4;
   assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
   assign branch_pc  = seq_pc + branch_off;
   // The jump region comes from the sequential pc, not pc itself, so a
   // jump in the last slot of a 256 MB region lands in the next region.
   assign jump_pc    = {seq_pc[31:28], instr_q[25:0], 2'b00};

   always_comb begin
      next_pc = seq_pc;
      case (NPCOp)
         NPC_SEQ:    next_pc = seq_pc;
         NPC_BRANCH: next_pc = branch_pc;
         NPC_JUMP:   next_pc = jump_pc;
         NPC_REG:    next_pc = rs_val;
         default:    next_pc = seq_pc;
      endcase
   end

   // Only register jumps can produce an unaligned target; branch and jump
   // targets are word-aligned by construction.
   assign target_misaligned = (NPCOp == NPC_REG) && (rs_val[1:0] != 2'b00);

   // ------------------------------------------------------------------
   // Control FSM: next state and datapath updates
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      code_d     = code_q;
      wait_cnt_d = wait_cnt_q;
      imem_req   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!hold) begin
               state_d    = S_FETCH;
               wait_cnt_d = 8'd0;
            end
         end

         S_FETCH: begin
            imem_req = 1'b1;
            // A response arriving on the limit cycle still completes the
            // fetch; the timeout is only taken when rdy is also low.
            if (imem_rdy) begin
               instr_d = imem_rdata;
               state_d = S_ISSUE;
            end else if (wait_cnt_q == TIMEOUT_LIMIT) begin
               state_d = S_FAULT;
               code_d  = CODE_TIMEOUT;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end

         S_ISSUE: begin
            if (exec_done) begin
               if (target_misaligned) begin
                  // pc keeps the address of the faulting instruction.
                  state_d = S_FAULT;
                  code_d  = CODE_MISALIGN;
               end else begin
                  pc_d       = next_pc;
                  state_d    = S_FETCH;
                  wait_cnt_d = 8'd0;
               end
            end
         end

         S_FAULT: begin
            // Sticky: nothing but reset leaves this state.
            state_d = S_FAULT;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= 32'd0;
         code_q     <= CODE_NONE;
         wait_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         code_q     <= code_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // ISSUE is entered on the edge that captures Instru, so decoding the
   // state gives a valid flag that rises exactly one cycle after rdy.
   assign instr_valid = (state_q == S_ISSUE);
   assign fault       = (state_q == S_FAULT);
   assign fault_code  = code_q;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign pc_plus4    = seq_pc;
   assign Instru      = instr_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rstn;
   logic        hold;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rdy;
   logic [31:0] imem_rdata;
   logic [31:0] Instru;
   logic        instr_valid;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [1:0]  NPCOp;
   logic [31:0] rs_val;
   logic        exec_done;
   logic        fault;
   logic [1:0]  fault_code;

   always #5 clk = ~clk;

   ifu_fetch #(.RESET_PC(32'h0000_3000), .FETCH_TIMEOUT(TMO)) dut (
      .clk(clk), .rstn(rstn), .hold(hold),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
      .Instru(Instru), .instr_valid(instr_valid),
      .pc(pc), .pc_plus4(pc_plus4),
      .NPCOp(NPCOp), .rs_val(rs_val), .exec_done(exec_done),
      .fault(fault), .fault_code(fault_code)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference state: architectural pc and the instruction last delivered.
   logic [31:0] m_pc;
   logic [31:0] m_instr;

   typedef struct {
      int          wt;
      logic [31:0] word;
      logic [1:0]  op;
      logic [31:0] rs;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Next pc from the instruction-set rules, using plain arithmetic.
   function automatic logic [31:0] ref_next(input logic [1:0] op, input logic [31:0] cur,
                                            input logic [31:0] ins, input logic [31:0] rs);
      logic [31:0] seq;
      int          off;
      seq = cur + 32'd4;
      case (op)
         2'd0:    return seq;
         2'd1: begin
            off = $signed(ins[15:0]) * 4;
            return seq + 32'(off);
         end
         2'd2:    return (seq & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
         default: return rs;
      endcase
   endfunction

   // Assert reset mid-cycle, check the asynchronous values, release, and
   // leave the unit in its first FETCH cycle.
   task automatic do_reset();
      imem_rdy  = 1'b0;
      exec_done = 1'b0;
      hold      = 1'b0;
      rstn      = 1'b0;
      #2;
      chk ("rst_pc",    pc,          32'h0000_3000);
      chk ("rst_addr",  imem_addr,   32'h0000_3000);
      chk ("rst_p4",    pc_plus4,    32'h0000_3004);
      chk ("rst_instr", Instru,      32'h0);
      chk1("rst_valid", instr_valid, 1'b0);
      chk1("rst_req",   imem_req,    1'b0);
      chk1("rst_fault", fault,       1'b0);
      chk ("rst_code",  32'(fault_code), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      tick();
      m_pc    = 32'h0000_3000;
      m_instr = 32'h0;
   endtask

   // Serve one fetch with wt wait cycles; rdy arrives in FETCH cycle wt.
   task automatic do_fetch(input int wt, input logic [31:0] word);
      for (int i = 0; i <= wt; i++) begin
         chk1("fetch_req",   imem_req,    1'b1);
         chk ("fetch_addr",  imem_addr,   m_pc);
         chk1("fetch_valid", instr_valid, 1'b0);
         if (i == wt) begin
            imem_rdy   = 1'b1;
            imem_rdata = word;
         end else begin
            imem_rdy   = 1'b0;
            imem_rdata = $urandom;
         end
         // exec_done and hold are don't-cares while fetching.
         exec_done = 1'($urandom_range(0, 1));
         NPCOp     = 2'($urandom_range(0, 3));
         rs_val    = $urandom;
         hold      = 1'($urandom_range(0, 1));
         tick();
      end
      imem_rdy   = 1'b0;
      imem_rdata = $urandom;
      exec_done  = 1'b0;
      m_instr    = word;
      chk1("issue_valid", instr_valid, 1'b1);
      chk ("issue_instr", Instru,      word);
      chk ("issue_pc",    pc,          m_pc);
      chk ("issue_p4",    pc_plus4,    m_pc + 32'd4);
      chk1("issue_req",   imem_req,    1'b0);
      chk1("issue_fault", fault,       1'b0);
   endtask

   // Stall in ISSUE with stray rdy pulses that must be ignored.
   task automatic issue_idle(input int n);
      for (int i = 0; i < n; i++) begin
         exec_done  = 1'b0;
         imem_rdy   = 1'($urandom_range(0, 1));
         imem_rdata = $urandom;
         hold       = 1'($urandom_range(0, 1));
         tick();
         chk1("idle_valid", instr_valid, 1'b1);
         chk ("idle_instr", Instru,      m_instr);
         chk ("idle_pc",    pc,          m_pc);
         chk1("idle_req",   imem_req,    1'b0);
      end
      imem_rdy = 1'b0;
   endtask

   task automatic do_retire(input logic [1:0] op, input logic [31:0] rs, output logic flt);
      exec_done = 1'b1;
      NPCOp     = op;
      rs_val    = rs;
      imem_rdy  = 1'($urandom_range(0, 1));
      hold      = 1'($urandom_range(0, 1));
      tick();
      exec_done = 1'b0;
      imem_rdy  = 1'b0;
      if (op == 2'd3 && rs[1:0] != 2'b00) begin
         flt = 1'b1;
         chk1("mis_fault", fault,       1'b1);
         chk ("mis_code",  32'(fault_code), 32'h1);
         chk1("mis_req",   imem_req,    1'b0);
         chk1("mis_valid", instr_valid, 1'b0);
         chk ("mis_pc",    pc,          m_pc);
      end else begin
         flt  = 1'b0;
         m_pc = ref_next(op, m_pc, m_instr, rs);
         chk1("ret_req",   imem_req,    1'b1);
         chk ("ret_addr",  imem_addr,   m_pc);
         chk1("ret_valid", instr_valid, 1'b0);
         chk1("ret_fault", fault,       1'b0);
         chk ("ret_code",  32'(fault_code), 32'h0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, %0d vectors so far", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      logic        flt;
      int          cnt;
      logic [31:0] word;
      logic [31:0] rs;
      logic [1:0]  op;
      int          wt;

      tbl[0]  = '{0, 32'h2400_0001, 2'd0, 32'h0,         32'h0000_3004};
      tbl[1]  = '{0, 32'h2400_0002, 2'd0, 32'h0,         32'h0000_3008};
      tbl[2]  = '{0, 32'h2400_0003, 2'd0, 32'h0,         32'h0000_300C};
      tbl[3]  = '{5, 32'h2400_0004, 2'd0, 32'h0,         32'h0000_3010};
      tbl[4]  = '{1, 32'h1000_FFFE, 2'd1, 32'h0,         32'h0000_300C};
      tbl[5]  = '{0, 32'h0800_0C40, 2'd2, 32'h0,         32'h0000_3100};
      tbl[6]  = '{3, 32'h0000_0008, 2'd3, 32'h0000_3010, 32'h0000_3010};
      tbl[7]  = '{0, 32'h1000_0004, 2'd1, 32'h0,         32'h0000_3024};
      tbl[8]  = '{2, 32'h0000_0008, 2'd3, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
      tbl[9]  = '{0, 32'h0000_0000, 2'd0, 32'h0,         32'h0000_0000};
      tbl[10] = '{1, 32'h0BFF_FFFF, 2'd2, 32'h0,         32'h0FFF_FFFC};
      tbl[11] = '{0, 32'h1000_7FFF, 2'd1, 32'h0,         32'h1001_FFFC};
      tbl[12] = '{0, 32'h1000_8000, 2'd1, 32'h0,         32'h1000_0000};

      rstn       = 1'b0;
      hold       = 1'b1;
      imem_rdy   = 1'b0;
      imem_rdata = 32'h0;
      NPCOp      = 2'd0;
      rs_val     = 32'h0;
      exec_done  = 1'b0;
      #12;
      chk ("init_pc",    pc,          32'h0000_3000);
      chk ("init_instr", Instru,      32'h0);
      chk1("init_req",   imem_req,    1'b0);
      chk1("init_valid", instr_valid, 1'b0);
      chk1("init_fault", fault,       1'b0);
      chk ("init_code",  32'(fault_code), 32'h0);

      // Boot hold keeps the unit idle.
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exec_done = 1'b1;
         imem_rdy  = 1'b1;
         tick();
         chk1("hold_req",   imem_req,    1'b0);
         chk1("hold_valid", instr_valid, 1'b0);
         chk ("hold_pc",    pc,          32'h0000_3000);
      end
      exec_done = 1'b0;
      imem_rdy  = 1'b0;
      hold      = 1'b0;
      tick();
      m_pc    = 32'h0000_3000;
      m_instr = 32'h0;

      // Directed table.
      for (int i = 0; i < 13; i++) begin
         do_fetch(tbl[i].wt, tbl[i].word);
         if (i == 9) chk("wrap_p4", pc_plus4, 32'h0);
         do_retire(tbl[i].op, tbl[i].rs, flt);
         chk("tbl_pc", pc, tbl[i].exp_pc);
         $display("vec %0d: op=%0d instr=%h wait=%0d -> pc %h", i, tbl[i].op, tbl[i].word,
                  tbl[i].wt, pc);
      end

      // Misaligned register jump: sticky fault until reset.
      do_fetch(0, 32'h0000_0008);
      do_retire(2'd3, 32'h0000_3402, flt);
      for (int i = 0; i < 8; i++) begin
         exec_done  = 1'($urandom_range(0, 1));
         imem_rdy   = 1'($urandom_range(0, 1));
         hold       = 1'($urandom_range(0, 1));
         NPCOp      = 2'($urandom_range(0, 3));
         rs_val     = $urandom;
         tick();
         chk1("stk_fault", fault,       1'b1);
         chk ("stk_code",  32'(fault_code), 32'h1);
         chk1("stk_req",   imem_req,    1'b0);
         chk1("stk_valid", instr_valid, 1'b0);
         chk ("stk_pc",    pc,          32'h1000_0000);
         chk ("stk_instr", Instru,      32'h0000_0008);
      end
      $display("seq misaligned: fault=%b code=%0d pc=%h", fault, fault_code, pc);
      do_reset();

      // Timeout: rdy never comes.
      imem_rdy = 1'b0;
      cnt = 0;
      while (imem_req && cnt < 400) begin
         cnt++;
         tick();
      end
      chk ("tmo_cycles", 32'(cnt), 32'(TMO + 1));
      chk1("tmo_fault",  fault,    1'b1);
      chk ("tmo_code",   32'(fault_code), 32'h2);
      chk ("tmo_pc",     pc,       32'h0000_3000);
      $display("seq timeout: req cycles=%0d fault=%b code=%0d", cnt, fault, fault_code);
      do_reset();

      // rdy on the limit cycle wins.
      do_fetch(TMO, 32'hABCD_0123);
      chk1("lim_fault", fault, 1'b0);
      do_retire(2'd0, 32'h0, flt);
      $display("seq limit rdy: instr=%h pc=%h", Instru, pc);

      // Reset in the middle of a fetch.
      do_fetch(2, 32'h1234_5678);
      do_retire(2'd0, 32'h0, flt);
      chk("mid_pc", pc, 32'h0000_3008);
      for (int i = 0; i < 3; i++) tick();
      do_reset();
      $display("seq mid-fetch reset: pc=%h", pc);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 250; k++) begin
         wt   = $urandom_range(0, 6);
         word = $urandom;
         do_fetch(wt, word);
         issue_idle($urandom_range(0, 2));
         op = 2'($urandom_range(0, 3));
         rs = $urandom;
         if ($urandom_range(0, 9) != 0) rs[1:0] = 2'b00;
         do_retire(op, rs, flt);
         $display("rnd %0d: op=%0d instr=%h wait=%0d -> pc %h fault=%b", k, op, word, wt, pc,
                  fault);
         if (flt) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
